// File: rtl/crypt_permute_pipe.sv
// crypt_permute_pipe: ROUNDS-stage keyed byte-permutation pipeline with valid/ready flow control.
// Define PERM_BYPASS_EN to add a per-transaction in_bypass that passes data through unpermuted.
module crypt_permute_pipe #(
   parameter int LANES  = 4,
   parameter int ROUNDS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*LANES-1:0]  in_data,
   input  logic [2*ROUNDS-1:0] in_key,
   input  logic                in_decrypt,
`ifdef PERM_BYPASS_EN
   input  logic                in_bypass,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*LANES-1:0]  out_data
);
   localparam int W  = 8*LANES;
   localparam int KW = 2*ROUNDS;

   function automatic logic [7:0] perm(input logic [7:0] a, input logic [1:0] s);
      return s == 2'b00 ? {a[6], a[7], a[4], a[5], a[2], a[3], a[0], a[1]} :
             s == 2'b10 ? {a[3:0], a[7:4]} :
             s == 2'b01 ? {a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7]} :
                          {a[1], a[6], a[3], a[4], a[5], a[2], a[7], a[0]};
   endfunction

   logic [ROUNDS-1:0] valid, sv;
   logic [ROUNDS:0]   ready;
   logic              dec [ROUNDS];
   logic              sd [ROUNDS];
   logic [W-1:0]      data [ROUNDS];
   logic [W-1:0]      sdat [ROUNDS];
   logic [W-1:0]      nxt [ROUNDS];
   logic [KW-1:0]     key [ROUNDS];
   logic [KW-1:0]     skey [ROUNDS];
   logic [1:0]        sel [ROUNDS];
`ifdef PERM_BYPASS_EN
   logic              byp [ROUNDS];
   logic              sb [ROUNDS];
`endif

   // Stage r's source is the input port for r=0 and stage r-1 otherwise.
   always_comb begin
      ready[ROUNDS] = out_ready;
      for (int r = ROUNDS-1; r >= 0; r--) ready[r] = ~valid[r] | ready[r+1];
      sv[0]   = in_valid;
      sdat[0] = in_data;
      skey[0] = in_key;
      sd[0]   = in_decrypt;
`ifdef PERM_BYPASS_EN
      sb[0]   = in_bypass;
`endif
      for (int r = 1; r < ROUNDS; r++) begin
         sv[r]   = valid[r-1];
         sdat[r] = data[r-1];
         skey[r] = key[r-1];
         sd[r]   = dec[r-1];
`ifdef PERM_BYPASS_EN
         sb[r]   = byp[r-1];
`endif
      end
      for (int r = 0; r < ROUNDS; r++) begin
         sel[r] = skey[r][2*(sd[r] ? ROUNDS-1-r : r) +: 2];
         nxt[r] = '0;
         for (int l = 0; l < LANES; l++) nxt[r][8*l +: 8] = perm(sdat[r][8*l +: 8], sel[r]);
`ifdef PERM_BYPASS_EN
         if (sb[r]) nxt[r] = sdat[r];
`endif
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int r = 0; r < ROUNDS; r++) begin
            valid[r] <= 1'b0;
            data[r]  <= '0;
            key[r]   <= '0;
            dec[r]   <= 1'b0;
`ifdef PERM_BYPASS_EN
            byp[r]   <= 1'b0;
`endif
         end
      else
         for (int r = 0; r < ROUNDS; r++)
            if (ready[r]) begin
               valid[r] <= sv[r];
               data[r]  <= nxt[r];
               key[r]   <= skey[r];
               dec[r]   <= sd[r];
`ifdef PERM_BYPASS_EN
               byp[r]   <= sb[r];
`endif
            end

   assign in_ready  = ready[0];
   assign out_valid = valid[ROUNDS-1];
   assign out_data  = data[ROUNDS-1];
endmodule

// File: tb/tb_crypt_permute_pipe.sv
// tb_crypt_permute_pipe: directed and randomized checks of crypt_permute_pipe against a
// queue-based reference model built from the per-byte permutation tables.
module tb_crypt_permute_pipe;
   localparam int LANES  = 4;
   localparam int ROUNDS = 4;
   localparam int W      = 8*LANES;
   localparam int KW     = 2*ROUNDS;

   logic          clk = 1'b0, reset = 1'b1;
   logic          in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b1, byp = 1'b0;
   logic          in_ready, out_valid;
   logic [W-1:0]  in_data = '0, out_data;
   logic [KW-1:0] in_key = '0;
   int            checks = 0, errors = 0, inflight = 0;
   bit            pushed, popped;
   logic [W-1:0]  exp_q[$], got_q[$];
   // Source bit of each output bit, listed MSB first, indexed by slice value {hi,lo}.
   int tbl [4][8] = '{'{6,7,4,5,2,3,0,1}, '{0,1,2,3,4,5,6,7}, '{3,2,1,0,7,6,5,4}, '{1,6,3,4,5,2,7,0}};

   always #5 clk = ~clk;

   crypt_permute_pipe #(.LANES(LANES), .ROUNDS(ROUNDS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_key(in_key), .in_decrypt(in_decrypt),
`ifdef PERM_BYPASS_EN
      .in_bypass(byp),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

   function automatic logic [7:0] pbyte(input logic [7:0] a, input logic [1:0] s);
      logic [7:0] o;
      for (int j = 0; j < 8; j++) o[7-j] = a[tbl[s][j]];
      return o;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [KW-1:0] k,
                                          input logic d, input logic b);
      logic [1:0] sl [$];
      for (int r = 0; r < ROUNDS; r++) sl.push_back(k[2*r +: 2]);
      if (d) sl.reverse();
      if (b) return x;
      foreach (sl[i]) for (int l = 0; l < LANES; l++) x[8*l +: 8] = pbyte(x[8*l +: 8], sl[i]);
      return x;
   endfunction

   // Called at a falling edge with inputs set; samples handshakes just before the rising edge.
   task automatic cycle();
      #2;
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      if (popped) begin got_q.push_back(out_data); inflight--; end
      if (pushed) begin exp_q.push_back(model(in_data, in_key, in_decrypt, byp)); inflight++; end
      @(negedge clk);
   endtask

   task automatic send_wait(input logic [W-1:0] d, input logic [KW-1:0] k, input logic dc,
                            output int lat, output logic [W-1:0] res);
      in_data = d; in_key = k; in_decrypt = dc; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin cycle(); lat++; end
      res = out_data;
      cycle();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_vector(input string name, input logic [W-1:0] d, input logic [KW-1:0] k,
                              input logic dc, input logic [W-1:0] want);
      int lat; logic [W-1:0] res;
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_pre got %b want 1", name, in_ready); end
      send_wait(d, k, dc, lat, res);
      checks++; if (lat !== ROUNDS) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, ROUNDS); end
      checks++; if (res !== want) begin errors++; $display("FAIL %s_data got %h want %h", name, res, want); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_post got %b want 1", name, in_ready); end
   endtask

   task automatic test_backpressure();
      int acc = 0, n = 0;
      logic [W-1:0] held;
      bit stable = 1'b1;
      exp_q.delete(); got_q.delete();
      out_ready = 1'b0; in_key = '0; in_decrypt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = acc < 6; in_data = W'(acc + 1);
         cycle();
         if (pushed) acc++;
      end
      checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      held = out_data;
      checks++; if (held !== W'(1) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head got %h/%b want 00000001/1", held, out_valid); end
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (out_data !== held || out_valid !== 1'b1 || pushed) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable want stable"); end
      out_ready = 1'b1;
      while (got_q.size() < 6 && n < 20) begin
         in_valid = acc < 6; in_data = W'(acc + 1);
         cycle();
         if (n == 0) begin
            checks++; if (!(pushed && popped)) begin errors++; $display("FAIL bp_push_pop got %b%b want 11", pushed, popped); end
         end
         if (pushed) acc++;
         n++;
      end
      in_valid = 1'b0;
      checks++; if (n !== 6) begin errors++; $display("FAIL bp_drain_cycles got %0d want 6", n); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== W'(i + 1)) begin
            errors++; $display("FAIL bp_order[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : 'x, W'(i + 1));
         end
      end
   endtask

   task automatic test_streaming();
      int sent = 0, n = 0;
      exp_q.delete(); got_q.delete();
      in_valid = 1'b0;
      while ((sent < 200 || inflight > 0) && n < 5000) begin
         if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; in_data = $urandom; in_key = KW'($urandom);
            in_decrypt = 1'($urandom_range(0, 1));
`ifdef PERM_BYPASS_EN
            byp = $urandom_range(0, 7) == 0;
`endif
         end
         out_ready = 1'($urandom_range(0, 1));
         cycle();
         if (pushed) begin sent++; in_valid = 1'b0; end
         checks++;
         if (in_ready !== (inflight < ROUNDS || out_ready)) begin
            errors++; $display("FAIL stream_ready got %b want %b (inflight %0d)", in_ready, inflight < ROUNDS || out_ready, inflight);
         end
         n++;
      end
      in_valid = 1'b0; byp = 1'b0; out_ready = 1'b1;
      checks++; if (got_q.size() !== 200) begin errors++; $display("FAIL stream_count got %0d want 200", got_q.size()); end
      for (int i = 0; i < 200 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midflight();
      int lat; logic [W-1:0] res;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'hDEADBEEF + W'(i); in_key = KW'($urandom); in_decrypt = 1'b0;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
      #1 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_reset_data got %h want 0", out_data); end
      @(negedge clk);
      reset = 1'b0; inflight = 0; exp_q.delete(); got_q.delete();
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
      send_wait(32'hCAFEF00D, 8'h5A, 1'b0, lat, res);
      checks++; if (lat !== ROUNDS) begin errors++; $display("FAIL mid_latency got %0d want %0d", lat, ROUNDS); end
      checks++; if (res !== model(32'hCAFEF00D, 8'h5A, 1'b0, 1'b0)) begin errors++; $display("FAIL mid_data got %h want %h", res, model(32'hCAFEF00D, 8'h5A, 1'b0, 1'b0)); end
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_stale got %0d outputs want 1", got_q.size()); end
   endtask

`ifdef PERM_BYPASS_EN
   task automatic test_bypass();
      int lat; logic [W-1:0] res, d;
      d = $urandom; byp = 1'b1;
      send_wait(d, 8'hFF, 1'b0, lat, res);
      byp = 1'b0;
      checks++; if (lat !== ROUNDS) begin errors++; $display("FAIL bypass_latency got %0d want %0d", lat, ROUNDS); end
      checks++; if (res !== d) begin errors++; $display("FAIL bypass_data got %h want %h", res, d); end
   endtask
`endif

   initial begin
      test_reset();
      test_vector("identity", 32'h12345678, 8'h00, 1'b0, 32'h12345678);
      test_vector("encrypt", 32'h12121212, 8'h01, 1'b0, 32'h84848484);
      test_vector("decrypt", 32'h84848484, 8'h01, 1'b1, 32'h12121212);
      test_backpressure();
      test_streaming();
      test_reset_midflight();
`ifdef PERM_BYPASS_EN
      test_bypass();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/crypt_permute_pipe.md
Name: crypt_permute_pipe

Overview:
- Multi-round, multi-lane bit-permutation pipeline for the pipelined crypt datapath. Successor to the single-register 4-byte permutation stage.
- Applies ROUNDS keyed per-byte permutations to LANES byte lanes.
- Each round is a registered stage with valid/ready flow control.
- A decrypt mode replays the round keys in reverse order, so a ciphertext is restored to its plaintext.

Parameters:
- LANES, 4, number of 8-bit lanes; data width is 8*LANES.
- ROUNDS, 4, number of permutation rounds and pipeline stages (≥1); key width is 2*ROUNDS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  stage 0 can accept
- in_data  in  8*LANES  plaintext or ciphertext
- in_key  in  2*ROUNDS  round selects; slice r = in_key[2r+1:2r]
- in_decrypt  in  1  1 = apply rounds in reverse key order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  8*LANES  permuted result

Behaviour:
- Permutation per byte, selected by 2-bit slice s={hi,lo}. Output listed MSB..LSB in terms of input bits a7..a0:
  - s=00 PAIR: {a6,a7,a4,a5,a2,a3,a0,a1}
  - s=10 NIB: {a3,a2,a1,a0,a7,a6,a5,a4}
  - s=01 REV: {a0,a1,a2,a3,a4,a5,a6,a7}
  - s=11 CROSS: {a1,a6,a3,a4,a5,a2,a7,a0}
- All four permutations are involutions. The same permutation applies to every lane in a given round.
- Stage r (0..ROUNDS-1) holds: valid_r, data_r, key_r, dec_r.
  - Key and mode travel with the data through the pipeline.
  - Stage r uses slice r when dec=0, and slice ROUNDS-1-r when dec=1.
  - Stage 0 permutes in_data on capture. Stage r>0 permutes data_{r-1} on capture.
- Flow control:
  - ready_r = ~valid_r | ready_{r+1}; ready_ROUNDS = out_ready; in_ready = ready_0. The ready chain is combinational.
  - Stage r loads when ready_r is high: valid_r <= valid_{r-1} (valid_{-1} = in_valid). Otherwise it holds all fields.
  - A bubble never blocks: an empty stage always accepts.
- Outputs: out_valid = valid_{ROUNDS-1}; out_data = data_{ROUNDS-1}.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - No tri-state values are driven at any time.
- Latency is ROUNDS cycles from the in_valid&in_ready edge to out_valid, with no stall. Throughput is 1 transaction per cycle.
- Ordering is strict FIFO, and no transaction is dropped or duplicated under any ready pattern.
- Full pipeline with out_ready=0: in_ready=0. Simultaneous pop and push on a full pipeline is allowed, with a full shift and no bubble.
- Reset (asynchronous, any time including mid-flight):
  - All valid_r=0 and all data/key/mode fields=0.
  - out_valid=0, out_data=0. in_ready=1 once reset is released.
  - In-flight transactions are discarded.
- Decrypt correctness: for any key k, decrypting with k the output of encrypting x with k returns x.

Optional Feature:
- Macro PERM_BYPASS_EN.
- Defined:
  - Adds input in_bypass (1 bit), captured and carried per transaction.
  - When in_bypass=1, every stage passes data unmodified. Latency stays ROUNDS and ordering is preserved.
- Undefined: the port is absent and all transactions are permuted.

Test Plan:
- Identity: in_key=8'h00, dec=0, in_data=32'h12345678, out_ready=1 → out_data=32'h12345678 exactly 4 cycles later; in_ready stays 1.
- Encrypt: in_key=8'h01, dec=0, in_data=32'h12121212 → out_data=32'h84848484 (REV then PAIR x3).
- Decrypt: in_key=8'h01, dec=1, in_data=32'h84848484 → out_data=32'h12121212.
- Backpressure: out_ready=0, six back-to-back inputs 0x01..0x06 (key 8'h00) → exactly 4 accepted, then in_ready=0 and out_data held stable. Raise out_ready → outputs 0x01..0x06 appear in order with no gaps or duplicates.
- Streaming with random stalls: 200 random transactions, random out_ready (50%), mixed dec/key → every output matches the reference model in order. With a full pipeline, out_ready=1 and in_valid=1 give a push and pop in the same cycle.
- Reset mid-flight: with 3 transactions in flight, assert reset for 1 cycle → out_valid=0 and out_data=0 immediately. After release, a new transaction emerges after 4 cycles and no stale data appears. With PERM_BYPASS_EN, in_bypass=1 and in_key=8'hFF → data unchanged at latency 4.
